// File: rtl/uut_exec_wrapper.sv
// Runs one start/done core test on behalf of the autotest FSM, returning the
// core result and a start-to-done cycle count, with a hung-core timeout.
module uut_exec_wrapper #(
  parameter int unsigned IN_W    = 64,
  parameter int unsigned RES_W   = 64,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_uut,
  input  logic [IN_W-1:0]        input_to_UUT_1,
  output logic                   end_uut,
  output logic                   err_uut,
  output logic [RES_W+CNT_W-1:0] output_from_UUT_1,
  output logic                   core_rst,
  output logic                   core_start,
  output logic [IN_W-1:0]        core_data,
  input  logic                   core_done,
  input  logic [RES_W-1:0]       core_result
);

  localparam int unsigned OUT_W = RES_W + CNT_W;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  state_e            state_q,      state_d;
  logic              core_rst_q,   core_rst_d;
  logic              core_start_q, core_start_d;
  logic [IN_W-1:0]   core_data_q,  core_data_d;
  logic              end_q,        end_d;
  logic              err_q,        err_d;
  logic [OUT_W-1:0]  out_q,        out_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [CNT_W-1:0]  cnt_inc_s;

  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-output computation for the run sequencer.
  always_comb begin
    state_d      = state_q;
    core_rst_d   = core_rst_q;
    core_start_d = core_start_q;
    core_data_d  = core_data_q;
    end_d        = end_q;
    err_d        = err_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    if (rst_uut) begin
      state_d      = S_IDLE;
      core_rst_d   = 1'b1;
      core_start_d = 1'b0;
      end_d        = 1'b0;
      err_d        = 1'b0;
      out_d        = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          core_data_d  = input_to_UUT_1;
          cnt_d        = '0;
          core_rst_d   = 1'b0;
          core_start_d = 1'b1;
          state_d      = S_START;
        end
        S_START: begin
          core_rst_d   = 1'b0;
          core_start_d = 1'b0;
          state_d      = S_RUN;
        end
        S_RUN: begin
          cnt_d = cnt_inc_s;
          // A done that lands on the timeout cycle still counts as a pass.
          if (core_done) begin
            out_d   = {cnt_inc_s, core_result};
            end_d   = 1'b1;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            out_d      = {TIMEOUT_C, {RES_W{1'b0}}};
            end_d      = 1'b1;
            err_d      = 1'b1;
            core_rst_d = 1'b1;
            state_d    = S_ERROR;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d      = S_IDLE;
          core_rst_d   = 1'b1;
          core_start_d = 1'b0;
          end_d        = 1'b0;
          err_d        = 1'b0;
          out_d        = '0;
        end
      endcase
    end
  end

  // State and registered-output flops with synchronous global reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      core_rst_q   <= 1'b1;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      end_q        <= 1'b0;
      err_q        <= 1'b0;
      out_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      core_rst_q   <= core_rst_d;
      core_start_q <= core_start_d;
      core_data_q  <= core_data_d;
      end_q        <= end_d;
      err_q        <= err_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
    end
  end

  assign end_uut           = end_q;
  assign err_uut           = err_q;
  assign output_from_UUT_1 = out_q;
  assign core_rst          = core_rst_q;
  assign core_start        = core_start_q;
  assign core_data         = core_data_q;

endmodule

// File: tb/tb_uut_exec_wrapper.sv
// Directed bench for uut_exec_wrapper: a run-level model checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_uut_exec_wrapper;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_uut;
  logic [63:0] in_v;
  logic        end_uut;
  logic        err_uut;
  logic [95:0] out_v;
  logic        core_rst;
  logic        core_start;
  logic [63:0] core_data;
  logic        core_done;
  logic [63:0] core_result;

  int passed = 0;
  int total  = 0;
  int sp;

  // Run-level model: active flag, index of the current cycle since start,
  // and the cycle at which the run finished (-1 while still running).
  bit          m_valid  = 1'b0;
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_fin    = -1;
  bit          m_err    = 1'b0;
  logic [31:0] m_cnt    = 32'd0;
  logic [63:0] m_res    = 64'd0;
  logic [63:0] m_data   = 64'd0;

  uut_exec_wrapper #(
    .IN_W(64), .RES_W(64), .CNT_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rst_uut(rst_uut), .input_to_UUT_1(in_v),
    .end_uut(end_uut), .err_uut(err_uut), .output_from_UUT_1(out_v),
    .core_rst(core_rst), .core_start(core_start), .core_data(core_data),
    .core_done(core_done), .core_result(core_result)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic do_run(input logic [63:0] vec, input int done_at, input bit lvl,
                        input logic [63:0] res, input int ncyc, output int pulses);
    pulses = 0;
    in_v = vec;
    core_result = res;
    core_done = 1'b0;
    @(negedge clk);
    rst_uut = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      core_done = lvl ? (done_at >= 0 && k >= done_at) : (k == done_at);
      if (k == 2) in_v = ~vec;
      @(negedge clk);
      if (core_start === 1'b1) pulses = pulses + 1;
    end
  endtask

  task automatic end_run();
    rst_uut = 1'b1;
    core_done = 1'b0;
    @(negedge clk);
    check("cleared_end", 96'(end_uut), 96'd0);
    check("cleared_out", out_v, 96'd0);
  endtask

  initial begin
    rst = 1'b1;
    rst_uut = 1'b1;
    in_v = 64'd0;
    core_done = 1'b0;
    core_result = 64'd0;

    fork
      forever begin
        @(posedge clk);
        if (rst) begin
          m_valid = 1'b1; m_active = 1'b0; m_fin = -1; m_data = 64'd0;
        end else if (rst_uut) begin
          m_active = 1'b0; m_fin = -1;
        end else if (!m_active) begin
          m_active = 1'b1; m_t = 0; m_fin = -1; m_data = in_v;
        end else begin
          if (m_fin < 0 && m_t >= 1) begin
            if (core_done) begin
              m_fin = m_t; m_cnt = 32'(m_t); m_res = core_result; m_err = 1'b0;
            end else if (m_t == TO) begin
              m_fin = m_t; m_cnt = 32'(TO); m_res = 64'd0; m_err = 1'b1;
            end
          end
          m_t = m_t + 1;
        end
      end
      forever begin
        logic e_rst, e_start, e_end, e_err;
        logic [95:0] e_out;
        @(negedge clk);
        if (m_valid) begin
          if (!m_active) begin
            e_rst = 1'b1; e_start = 1'b0; e_end = 1'b0; e_err = 1'b0; e_out = 96'd0;
          end else if (m_t == 0) begin
            e_rst = 1'b0; e_start = 1'b1; e_end = 1'b0; e_err = 1'b0; e_out = 96'd0;
          end else if (m_fin < 0) begin
            e_rst = 1'b0; e_start = 1'b0; e_end = 1'b0; e_err = 1'b0; e_out = 96'd0;
          end else begin
            e_rst = m_err; e_start = 1'b0; e_end = 1'b1; e_err = m_err; e_out = {m_cnt, m_res};
          end
          check("cyc_core_rst", 96'(core_rst), 96'(e_rst));
          check("cyc_core_start", 96'(core_start), 96'(e_start));
          check("cyc_end_uut", 96'(end_uut), 96'(e_end));
          check("cyc_err_uut", 96'(err_uut), 96'(e_err));
          check("cyc_output", out_v, e_out);
          check("cyc_core_data", 96'(core_data), 96'(m_data));
        end
      end
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_end", 96'(end_uut), 96'd0);
    check("rst_err", 96'(err_uut), 96'd0);
    check("rst_out", out_v, 96'd0);
    check("rst_core_rst", 96'(core_rst), 96'd1);
    check("rst_core_data", 96'(core_data), 96'd0);

    // Normal pass: done 10 cycles after the start pulse.
    do_run(64'h0123456789ABCDEF, 10, 1'b0, 64'hDEADBEEFCAFEF00D, 14, sp);
    check("pass_out", out_v, {32'd10, 64'hDEADBEEFCAFEF00D});
    check("pass_end", 96'(end_uut), 96'd1);
    check("pass_err", 96'(err_uut), 96'd0);
    check("pass_core_data", 96'(core_data), 96'h0123456789ABCDEF);
    check("pass_start_pulses", 96'(sp), 96'd1);
    end_run();

    // Hung core: timeout after TO cycles.
    do_run(64'h1111111111111111, -1, 1'b0, 64'h5555555555555555, 20, sp);
    check("to_out", out_v, {32'd16, 64'd0});
    check("to_end", 96'(end_uut), 96'd1);
    check("to_err", 96'(err_uut), 96'd1);
    check("to_core_rst", 96'(core_rst), 96'd1);
    end_run();

    // Done lands exactly on the timeout cycle.
    do_run(64'h2222222222222222, 16, 1'b0, 64'hA5A5A5A5A5A5A5A5, 20, sp);
    check("edge_out", out_v, {32'd16, 64'hA5A5A5A5A5A5A5A5});
    check("edge_err", 96'(err_uut), 96'd0);
    check("edge_core_rst", 96'(core_rst), 96'd0);
    end_run();

    // Abort mid-run, then a fresh run with a new vector.
    do_run(64'h3333333333333333, -1, 1'b0, 64'd0, 6, sp);
    rst_uut = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_end", 96'(end_uut), 96'd0);
    check("abort_core_rst", 96'(core_rst), 96'd1);
    do_run(64'h4444444444444444, 3, 1'b1, 64'h000000000000BEEF, 8, sp);
    check("restart_core_data", 96'(core_data), 96'h4444444444444444);
    check("restart_out", out_v, {32'd3, 64'h000000000000BEEF});
    check("restart_start_pulses", 96'(sp), 96'd1);
    end_run();

    // Done on the first cycle after start counts as 1.
    do_run(64'h5555555555555555, 1, 1'b1, 64'h0000000012345678, 5, sp);
    check("quick_out", out_v, {32'd1, 64'h0000000012345678});
    check("quick_err", 96'(err_uut), 96'd0);
    end_run();

    // Done pulse only during the start cycle is ignored, so the run times out.
    do_run(64'h6666666666666666, 0, 1'b0, 64'h0000000087654321, 20, sp);
    check("startdone_out", out_v, {32'd16, 64'd0});
    check("startdone_err", 96'(err_uut), 96'd1);
    end_run();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
